// File: rtl/ppu_pkg.sv
// ============================================================================
// Module : ppu_pkg
// Brief  : Shared PPU types and constants: sprite-DMA state encoding and
//          CPU/PPU register addresses.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] c_oam_dma_addr = 16'h4014;

    // PPU register selects as seen on the register interface
    localparam logic [2:0] c_reg_ppuctrl   = 3'h0;
    localparam logic [2:0] c_reg_ppumask   = 3'h1;
    localparam logic [2:0] c_reg_ppustatus = 3'h2;
    localparam logic [2:0] c_reg_oamaddr   = 3'h3;
    localparam logic [2:0] c_reg_oamdata   = 3'h4;
    localparam logic [2:0] c_reg_ppuscroll = 3'h5;
    localparam logic [2:0] c_reg_ppuaddr   = 3'h6;
    localparam logic [2:0] c_reg_ppudata   = 3'h7;

endpackage

`default_nettype wire

// File: rtl/ppu_oam_dma.sv
// ============================================================================
// Module : ppu_oam_dma
// Brief  : Sprite DMA for $4014: halts the CPU and copies a 256-byte page to
//          OAMDATA through the PPU register interface.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter logic [15:0] DMA_ADDR     = c_oam_dma_addr,
    parameter logic [2:0]  OAM_DATA_SEL = c_reg_oamdata
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        cpu_ce_in,
    input  logic [15:0] cpu_a_in,
    input  logic        cpu_r_nw_in,
    input  logic [7:0]  cpu_d_in,
    input  logic [7:0]  mem_d_in,
    output logic        cpu_rdy_out,
    output logic        dma_active_out,
    output logic [15:0] mem_a_out,
    output logic        mem_r_nw_out,
    output logic [2:0]  ri_sel_out,
    output logic        ri_ncs_out,
    output logic        ri_r_nw_out,
    output logic [7:0]  ri_d_out
);

    dma_state_t  r_state;
    logic [7:0]  r_page;
    logic [7:0]  r_cnt;
    logic [7:0]  r_buf;
    logic        r_parity;

    dma_state_t  w_state_nxt;
    logic [7:0]  w_page_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_buf_nxt;
    logic        w_parity_nxt;

    logic        w_rdy_nxt;
    logic [15:0] w_mem_a_nxt;
    logic [2:0]  w_ri_sel_nxt;
    logic        w_ri_wr_nxt;
    logic [7:0]  w_ri_d_nxt;

    always_comb begin
        w_state_nxt  = r_state;
        w_page_nxt   = r_page;
        w_cnt_nxt    = r_cnt;
        w_buf_nxt    = r_buf;
        w_parity_nxt = r_parity;

        if (cpu_ce_in) begin
            w_parity_nxt = ~r_parity;
            case (r_state)
                IDLE: begin
                    if (!cpu_r_nw_in && (cpu_a_in == DMA_ADDR)) begin
                        w_page_nxt  = cpu_d_in;
                        w_cnt_nxt   = 8'h00;
                        w_state_nxt = HALT;
                    end
                end
                // The read/write pairs must start on an even CPU cycle
                HALT:  w_state_nxt = w_parity_nxt ? ALIGN : READ;
                ALIGN: w_state_nxt = READ;
                READ: begin
                    w_buf_nxt   = mem_d_in;
                    w_state_nxt = WRITE;
                end
                WRITE: begin
                    w_cnt_nxt   = r_cnt + 8'h01;
                    w_state_nxt = (r_cnt == 8'hFF) ? IDLE : READ;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next-state values so they can be registered
    // without adding a cycle of lag.
    always_comb begin
        w_rdy_nxt    = (w_state_nxt == IDLE);
        w_ri_wr_nxt  = (w_state_nxt == WRITE);
        w_mem_a_nxt  = 16'h0000;
        w_ri_sel_nxt = 3'h0;
        w_ri_d_nxt   = 8'h00;
        if ((w_state_nxt == READ) || (w_state_nxt == WRITE)) begin
            w_mem_a_nxt = {w_page_nxt, w_cnt_nxt};
        end
        if (w_ri_wr_nxt) begin
            w_ri_sel_nxt = OAM_DATA_SEL;
            w_ri_d_nxt   = w_buf_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state        <= IDLE;
            r_page         <= 8'h00;
            r_cnt          <= 8'h00;
            r_buf          <= 8'h00;
            r_parity       <= 1'b0;
            cpu_rdy_out    <= 1'b1;
            dma_active_out <= 1'b0;
            mem_a_out      <= 16'h0000;
            mem_r_nw_out   <= 1'b1;
            ri_sel_out     <= 3'h0;
            ri_ncs_out     <= 1'b1;
            ri_r_nw_out    <= 1'b1;
            ri_d_out       <= 8'h00;
        end else begin
            r_state        <= w_state_nxt;
            r_page         <= w_page_nxt;
            r_cnt          <= w_cnt_nxt;
            r_buf          <= w_buf_nxt;
            r_parity       <= w_parity_nxt;
            cpu_rdy_out    <= w_rdy_nxt;
            dma_active_out <= ~w_rdy_nxt;
            mem_a_out      <= w_mem_a_nxt;
            mem_r_nw_out   <= 1'b1;
            ri_sel_out     <= w_ri_sel_nxt;
            ri_ncs_out     <= ~w_ri_wr_nxt;
            ri_r_nw_out    <= ~w_ri_wr_nxt;
            ri_d_out       <= w_ri_d_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ppu_oam_dma.sv
// ============================================================================
// Module : tb_ppu_oam_dma
// Brief  : Scoreboard bench for ppu_oam_dma: expected OAM writes are queued at
//          each trigger and popped on every ri_ncs_out falling edge.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ppu_oam_dma;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_wr_t;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        cpu_ce_in;
    logic [15:0] cpu_a_in;
    logic        cpu_r_nw_in;
    logic [7:0]  cpu_d_in;
    logic [7:0]  mem_d_in;
    logic        cpu_rdy_out;
    logic        dma_active_out;
    logic [15:0] mem_a_out;
    logic        mem_r_nw_out;
    logic [2:0]  ri_sel_out;
    logic        ri_ncs_out;
    logic        ri_r_nw_out;
    logic [7:0]  ri_d_out;

    int          checks = 0;
    int          errors = 0;
    int          ce_cnt = 0;
    int          wr_count = 0;
    int          ce_div = 0;
    logic        prev_ncs = 1'b1;
    exp_wr_t     exp_q[$];

    ppu_oam_dma dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .cpu_ce_in      (cpu_ce_in),
        .cpu_a_in       (cpu_a_in),
        .cpu_r_nw_in    (cpu_r_nw_in),
        .cpu_d_in       (cpu_d_in),
        .mem_d_in       (mem_d_in),
        .cpu_rdy_out    (cpu_rdy_out),
        .dma_active_out (dma_active_out),
        .mem_a_out      (mem_a_out),
        .mem_r_nw_out   (mem_r_nw_out),
        .ri_sel_out     (ri_sel_out),
        .ri_ncs_out     (ri_ncs_out),
        .ri_r_nw_out    (ri_r_nw_out),
        .ri_d_out       (ri_d_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory image: page 02 holds i^5A at offset i
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h58;
    endfunction

    assign mem_d_in = mem_f(mem_a_out);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One CPU cycle every three clocks
    initial begin
        cpu_ce_in = 1'b0;
        forever begin
            @(negedge clk_in);
            ce_div    = (ce_div == 2) ? 0 : ce_div + 1;
            cpu_ce_in = (ce_div == 2);
        end
    end

    always @(posedge clk_in) begin
        if (!rst_n_in) ce_cnt = 0;
        else if (cpu_ce_in) ce_cnt = ce_cnt + 1;
    end

    // Monitor: every falling edge of ncs is one OAM write
    always @(negedge clk_in) begin
        if (!rst_n_in) begin
            prev_ncs = 1'b1;
        end else begin
            if (prev_ncs && !ri_ncs_out) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    exp_wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_data", ri_d_out, e.data);
                    chk("wr_addr", mem_a_out, e.addr);
                    chk("wr_sel_rnw", {ri_sel_out, ri_r_nw_out, mem_r_nw_out}, {3'h4, 1'b0, 1'b1});
                end
            end
            prev_ncs = ri_ncs_out;
        end
    end

    // One CPU bus cycle; want_align: 1/0 forces the DMA alignment outcome, -1 any
    task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rnw,
                             input int want_align);
        @(posedge clk_in iff cpu_ce_in); #1;
        if (want_align >= 0) begin
            // Trigger edge T = ce_cnt+1 enters HALT; ALIGN follows when T is even
            if ((((ce_cnt + 1) % 2) == 0) != (want_align == 1)) begin
                @(posedge clk_in iff cpu_ce_in); #1;
            end
        end
        cpu_a_in = a; cpu_d_in = d; cpu_r_nw_in = rnw;
        @(posedge clk_in iff cpu_ce_in); #1;
        cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_rdy"}, cpu_rdy_out, 1);
        chk({name, "_active"}, dma_active_out, 0);
        chk({name, "_ncs"}, ri_ncs_out, 1);
        chk({name, "_outs"}, {ri_r_nw_out, ri_sel_out, ri_d_out, mem_a_out, mem_r_nw_out},
            {1'b1, 3'h0, 8'h00, 16'h0000, 1'b1});
    endtask

    task automatic push_page(input logic [7:0] p);
        for (int i = 0; i < 256; i++) begin
            exp_wr_t e;
            e.addr = {p, 8'(i)};
            e.data = mem_f(e.addr);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_transfer(input logic [7:0] p, input int align);
        int n;
        push_page(p);
        wr_count = 0;
        cpu_cycle(16'h4014, p, 1'b0, align);
        chk("halt_rdy_active", {cpu_rdy_out, dma_active_out}, {1'b0, 1'b1});
        chk("halt_mem_a", mem_a_out, 0);
        if (align == 1) begin
            @(posedge clk_in iff cpu_ce_in); #1;
            chk("align_mem_a", mem_a_out, 0);
            chk("align_ncs", ri_ncs_out, 1);
            n = 1;
        end else begin
            n = 0;
        end
        @(posedge clk_in iff cpu_ce_in); #1;
        n++;
        chk("first_read_addr", mem_a_out, {p, 8'h00});
        while (!cpu_rdy_out && n < 1000) begin
            @(posedge clk_in iff cpu_ce_in); #1;
            n++;
        end
        chk("rdy_low_cycles", n, (align == 1) ? 514 : 513);
        repeat (2) @(negedge clk_in);
        chk("write_count", wr_count, 256);
        chk("queue_empty", exp_q.size(), 0);
        check_idle("post_xfer");
        exp_q.delete();
    endtask

    initial begin
        int guard;
        rst_n_in = 1'b0;
        cpu_a_in = 16'h0000; cpu_d_in = 8'h00; cpu_r_nw_in = 1'b1;
        repeat (4) @(posedge clk_in);
        #1;
        check_idle("reset");
        @(negedge clk_in);
        rst_n_in = 1'b1;

        // Non-triggers: read of $4014, write to $4013
        cpu_cycle(16'h4014, 8'h02, 1'b1, -1);
        check_idle("read_4014");
        cpu_cycle(16'h4013, 8'h03, 1'b0, -1);
        repeat (3) @(posedge clk_in iff cpu_ce_in);
        #1;
        check_idle("write_4013");

        run_transfer(8'h02, 0);
        run_transfer(8'h02, 1);

        // Reset after write 100
        push_page(8'h05);
        wr_count = 0;
        cpu_cycle(16'h4014, 8'h05, 1'b0, -1);
        guard = 0;
        while (wr_count < 100 && guard < 2000) begin
            @(negedge clk_in);
            guard++;
        end
        chk("reached_write_100", wr_count, 100);
        @(posedge clk_in); #2;
        rst_n_in = 1'b0;
        #1;
        chk("rst_mid_ncs", ri_ncs_out, 1);
        chk("rst_mid_rdy", cpu_rdy_out, 1);
        chk("rst_mid_active", dma_active_out, 0);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        check_idle("after_rst");

        run_transfer(8'h07, -1 + 1);
        run_transfer(8'hFF, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
